e_mdu: RTL and testbench

- Multiply/divide unit in the E stage of the 5-stage MIPS pipeline.
- Consumes the operands the D→E pipeline register presents (E_RD1, E_RD2) together with a decoded MDU opcode from E_instr.
- Owns architectural HI/LO. Models multi-cycle mult/div latency with a busy counter.
- Exports `busy` so the stall controller can drop the D→E register's WE and flush while an MDU op is in flight.

---
 rtl/e_mdu.sv | 139 +++++++++++++
 tb/tb_e_mdu.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: owns HI/LO and models mult/div latency with a
// down-counter that holds busy high until the precomputed result commits.
module e_mdu #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] E_RD1,
    input  logic [31:0] E_RD2,
    input  logic [3:0]  mdu_op,
    input  logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mdu_out
);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8
    } mdu_op_e;

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      pend_hi_q, pend_hi_d;
    logic [31:0]      pend_lo_q, pend_lo_d;
    logic             pend_we_q, pend_we_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;

    // Result datapath, evaluated on the live operands and captured only at start.
    logic [63:0] prod_s, prod_u;
    logic        divisor_nz, a_neg, b_neg;
    logic [31:0] a_mag, b_mag, b_mag_safe, b_u_safe;
    logic [31:0] q_mag, r_mag, q_s, r_s, q_u, r_u;

    always_comb begin
        prod_s     = {{32{E_RD1[31]}}, E_RD1} * {{32{E_RD2[31]}}, E_RD2};
        prod_u     = {32'b0, E_RD1} * {32'b0, E_RD2};
        divisor_nz = (E_RD2 != 32'd0);
        a_neg      = E_RD1[31];
        b_neg      = E_RD2[31];
        // Magnitude of 0x80000000 wraps to itself, which reads correctly as 2^31.
        a_mag      = a_neg ? (32'd0 - E_RD1) : E_RD1;
        b_mag      = b_neg ? (32'd0 - E_RD2) : E_RD2;
        b_mag_safe = divisor_nz ? b_mag : 32'd1;
        b_u_safe   = divisor_nz ? E_RD2 : 32'd1;
        q_mag      = a_mag / b_mag_safe;
        r_mag      = a_mag % b_mag_safe;
        q_s        = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        r_s        = a_neg ? (32'd0 - r_mag) : r_mag;
        q_u        = E_RD1 / b_u_safe;
        r_u        = E_RD1 % b_u_safe;
    end

    always_comb begin
        // NOTE: every signal gets its hold value first so no path infers a latch.
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_we_d = pend_we_q;
        cnt_d     = cnt_q;

        if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1) && pend_we_q) begin
                hi_d = pend_hi_q;
                lo_d = pend_lo_q;
            end
        end else begin
            case (mdu_op_e'(mdu_op))
                OP_MULT, OP_MULTU: if (start) begin
                    pend_hi_d = (mdu_op == OP_MULT) ? prod_s[63:32] : prod_u[63:32];
                    pend_lo_d = (mdu_op == OP_MULT) ? prod_s[31:0]  : prod_u[31:0];
                    pend_we_d = 1'b1;
                    cnt_d     = CNT_W'(MULT_LAT);
                end
                OP_DIV, OP_DIVU: if (start) begin
                    pend_hi_d = (mdu_op == OP_DIV) ? r_s : r_u;
                    pend_lo_d = (mdu_op == OP_DIV) ? q_s : q_u;
                    // Divide by zero still occupies the unit but leaves HI/LO alone.
                    pend_we_d = divisor_nz;
                    cnt_d     = CNT_W'(DIV_LAT);
                end
                OP_MTHI: hi_d = E_RD1;
                OP_MTLO: lo_d = E_RD1;
                default: ;
            endcase
        end

        busy_d = (cnt_d != '0);
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_we_q <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
        end else begin
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_we_q <= pend_we_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        case (mdu_op_e'(mdu_op))
            OP_MFHI: mdu_out = hi_q;
            OP_MFLO: mdu_out = lo_q;
            default: mdu_out = 32'd0;
        endcase
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Directed-vector bench for e_mdu: latency, arithmetic corner cases, MT/MF
// access, interference while busy and reset abort.
module tb_e_mdu;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] e_rd1, e_rd2;
    logic [3:0]  mdu_op;
    logic        start;
    logic        busy;
    logic [31:0] hi, lo, mdu_out;

    int checks_total  = 0;
    int checks_passed = 0;

    e_mdu #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk    (clk),
        .rst    (rst),
        .E_RD1  (e_rd1),
        .E_RD2  (e_rd2),
        .mdu_op (mdu_op),
        .start  (start),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo),
        .mdu_out(mdu_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp) checks_passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one mult/div, scramble operands afterwards, and check every cycle
    // of the busy window plus the first cycle after commit.
    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b, input int lat,
                          input logic [31:0] pre_hi, input logic [31:0] pre_lo,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        mdu_op = op; start = 1'b1; e_rd1 = a; e_rd2 = b;
        step();
        start = 1'b0; mdu_op = 4'd0; e_rd1 = $urandom; e_rd2 = $urandom;
        for (int i = 1; i <= lat; i++) begin
            check($sformatf("%s busy c%0d", tag, i), {31'b0, busy}, 32'd1);
            check($sformatf("%s hi held c%0d", tag, i), hi, pre_hi);
            check($sformatf("%s lo held c%0d", tag, i), lo, pre_lo);
            step();
        end
        check($sformatf("%s busy low", tag), {31'b0, busy}, 32'd0);
        check($sformatf("%s hi", tag), hi, exp_hi);
        check($sformatf("%s lo", tag), lo, exp_lo);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; mdu_op = 4'd0; e_rd1 = '0; e_rd2 = '0;
        step(); step();
        rst = 1'b0;
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        check("reset mdu_out", mdu_out, 32'd0);

        run_op("mult", 4'd1, 32'hFFFF_FFFE, 32'd3, MULT_LAT,
               32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MULT_LAT,
               32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'hFFFF_FFFE, 32'h0000_0001);
        mdu_op = 4'd5; #1;
        check("mfhi", mdu_out, 32'hFFFF_FFFE);
        mdu_op = 4'd6; #1;
        check("mflo", mdu_out, 32'h0000_0001);
        mdu_op = 4'd9; #1;
        check("mdu_out other op", mdu_out, 32'd0);
        mdu_op = 4'd0;

        run_op("div neg", 4'd3, 32'hFFFF_FFF9, 32'd2, DIV_LAT,
               32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div negdiv", 4'd3, 32'd7, 32'hFFFF_FFFE, DIV_LAT,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h0000_0001, 32'hFFFF_FFFD);
        run_op("divu", 4'd4, 32'd7, 32'd2, DIV_LAT,
               32'h0000_0001, 32'hFFFF_FFFD, 32'd1, 32'd3);
        run_op("div ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT,
               32'd1, 32'd3, 32'd0, 32'h8000_0000);

        mdu_op = 4'd7; e_rd1 = 32'h11; step();
        check("mthi", hi, 32'h11);
        mdu_op = 4'd8; e_rd1 = 32'h22; step();
        check("mtlo", lo, 32'h22);
        check("mtlo keeps hi", hi, 32'h11);

        run_op("divu by 0", 4'd4, 32'd5, 32'd0, DIV_LAT,
               32'h11, 32'h22, 32'h11, 32'h22);
        run_op("div by 0", 4'd3, 32'hFFFF_FFF0, 32'd0, DIV_LAT,
               32'h11, 32'h22, 32'h11, 32'h22);

        // start with a non-mult/div opcode must not occupy the unit
        mdu_op = 4'd0; start = 1'b1; step();
        check("start op none", {31'b0, busy}, 32'd0);
        mdu_op = 4'd12; step();
        check("start op 12", {31'b0, busy}, 32'd0);
        start = 1'b0; mdu_op = 4'd0;

        // Interference: MULT 0x10000*0x30000 -> HI=3, LO=0
        mdu_op = 4'd1; start = 1'b1; e_rd1 = 32'h0001_0000; e_rd2 = 32'h0003_0000;
        step();
        mdu_op = 4'd3; start = 1'b1; e_rd1 = 32'd100; e_rd2 = 32'd0;
        step();
        check("intf busy c2", {31'b0, busy}, 32'd1);
        mdu_op = 4'd7; start = 1'b0; e_rd1 = 32'hAAAA;
        step();
        check("intf busy c3", {31'b0, busy}, 32'd1);
        check("intf mthi ignored", hi, 32'h11);
        mdu_op = 4'd8; e_rd1 = 32'hBBBB;
        step();
        check("intf mtlo ignored", lo, 32'h22);
        mdu_op = 4'd1; start = 1'b1; e_rd1 = 32'd9; e_rd2 = 32'd9;
        step();
        check("intf busy c5", {31'b0, busy}, 32'd1);
        start = 1'b0; mdu_op = 4'd0;
        step();
        check("intf busy low c6", {31'b0, busy}, 32'd0);
        check("intf hi", hi, 32'd3);
        check("intf lo", lo, 32'd0);

        // Reset abort: DIV 100/7 started, rst asserted in cycle 3
        mdu_op = 4'd3; start = 1'b1; e_rd1 = 32'd100; e_rd2 = 32'd7;
        step();
        start = 1'b0; mdu_op = 4'd0;
        check("rstmid busy c1", {31'b0, busy}, 32'd1);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstmid busy c4", {31'b0, busy}, 32'd0);
        check("rstmid hi c4", hi, 32'd0);
        check("rstmid lo c4", lo, 32'd0);
        for (int i = 0; i < DIV_LAT + 2; i++) step();
        check("rstmid no commit hi", hi, 32'd0);
        check("rstmid no commit lo", lo, 32'd0);
        check("rstmid busy later", {31'b0, busy}, 32'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
